// File: rtl/wb_bus_buffer_pkg.sv
// Shared definitions for the registered Wishbone bus buffer: FSM state
// encodings and default bus widths.
package wb_bus_buffer_pkg;

    localparam int WBB_DW = 32;
    localparam int WBB_AW = 19;

    typedef enum logic [1:0] {
        WBB_IDLE  = 2'd0,
        WBB_BUSY  = 2'd1,
        WBB_ABORT = 2'd2
    } wbb_state_e;

endpackage

// File: rtl/wb_skid.sv
// Output request register backed by a one-entry skid register.
// Requests leave in accept order; flush drops both entries.
module wb_skid #(
    parameter int W = 52
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_valid_nxt,
    output logic         o_skid_nxt
);

    logic         r_ovld, r_svld;
    logic [W-1:0] r_odat, r_sdat;
    logic         w_ovld, w_svld, w_free;
    logic [W-1:0] w_odat, w_sdat;

    assign w_free = !r_ovld || i_ready;

    always_comb begin
        w_ovld = r_ovld;
        w_svld = r_svld;
        w_odat = r_odat;
        w_sdat = r_sdat;
        if (w_free) begin
            // Output slot frees up: the skid entry is older, so it goes first.
            if (r_svld) begin
                w_odat = r_sdat;
                w_ovld = 1'b1;
                w_svld = i_valid;
                if (i_valid)
                    w_sdat = i_data;
            end else begin
                w_ovld = i_valid;
                if (i_valid)
                    w_odat = i_data;
            end
        end else if (i_valid) begin
            w_svld = 1'b1;
            w_sdat = i_data;
        end
        if (i_flush) begin
            w_ovld = 1'b0;
            w_svld = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovld <= 1'b0;
            r_svld <= 1'b0;
            r_odat <= '0;
            r_sdat <= '0;
        end else begin
            r_ovld <= w_ovld;
            r_svld <= w_svld;
            r_odat <= w_odat;
            r_sdat <= w_sdat;
        end
    end

    assign o_valid     = r_ovld;
    assign o_data      = r_odat;
    assign o_valid_nxt = w_ovld;
    assign o_skid_nxt  = w_svld;

endmodule

// File: rtl/wb_bus_buffer.sv
// Registered Wishbone pipeline stage between the arbiter and the slave
// interconnect: in-flight limiting, timeout abort and registered returns.
module wb_bus_buffer
    import wb_bus_buffer_pkg::*;
#(
    parameter int DW        = WBB_DW,
    parameter int AW        = WBB_AW,
    parameter int LGFLIGHT  = 4,
    parameter int LGTIMEOUT = 10
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cyc,
    input  logic          i_stb,
    input  logic          i_we,
    input  logic [AW-1:0] i_adr,
    input  logic [DW-1:0] i_dat,
    output logic          o_stall,
    output logic          o_ack,
    output logic          o_err,
    output logic [DW-1:0] o_data,
    output logic          o_cyc,
    output logic          o_stb,
    output logic          o_we,
    output logic [AW-1:0] o_adr,
    output logic [DW-1:0] o_dat,
    input  logic          i_stall,
    input  logic          i_ack,
    input  logic          i_err,
    input  logic [DW-1:0] i_data
);

    localparam int RW = 1 + AW + DW;
    // Stall is registered, so throttle one request early to stay under the limit.
    localparam int FL_THR_I = (2 ** LGFLIGHT) - 2;
    localparam logic [LGFLIGHT:0] FL_THR = FL_THR_I[LGFLIGHT:0];

    wbb_state_e           r_state, w_state_nxt;
    logic                 r_cyc, r_stall, r_ack, r_err;
    logic [DW-1:0]        r_data;
    logic [LGFLIGHT-1:0]  r_flight, w_flight_nxt;
    logic [LGTIMEOUT-1:0] r_tmo, w_tmo_nxt;
    logic                 w_accept, w_issue, w_dec, w_flush, w_abort, w_timeout;
    logic                 w_stb, w_stb_nxt, w_skid_nxt, w_stall_nxt;
    logic [RW-1:0]        w_req;
    logic [LGFLIGHT:0]    w_sum;

    assign w_timeout = &r_tmo;
    assign w_accept  = i_cyc && i_stb && !r_stall && (r_state != WBB_ABORT);
    assign w_issue   = w_stb && !i_stall;
    assign w_dec     = i_ack && (r_flight != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        case (r_state)
            WBB_IDLE:  if (i_cyc) w_state_nxt = WBB_BUSY;
            WBB_BUSY: begin
                if (!i_cyc) begin
                    w_state_nxt = WBB_IDLE;
                end else if (i_err || w_timeout) begin
                    w_state_nxt = WBB_ABORT;
                    w_abort     = 1'b1;
                end
            end
            WBB_ABORT: if (!i_cyc) w_state_nxt = WBB_IDLE;
            default:   w_state_nxt = WBB_IDLE;
        endcase
    end

    assign w_flush = (r_state == WBB_BUSY) && (w_state_nxt != WBB_BUSY);

    always_comb begin
        w_flight_nxt = r_flight;
        w_tmo_nxt    = r_tmo;
        if (w_flush || (r_state != WBB_BUSY)) begin
            w_flight_nxt = '0;
            w_tmo_nxt    = '0;
        end else begin
            case ({w_issue, w_dec})
                2'b10:   w_flight_nxt = r_flight + LGFLIGHT'(1);
                2'b01:   w_flight_nxt = r_flight - LGFLIGHT'(1);
                default: w_flight_nxt = r_flight;
            endcase
            if (i_ack || w_issue)
                w_tmo_nxt = '0;
            else if (((r_flight != '0) || w_stb) && !w_timeout)
                w_tmo_nxt = r_tmo + LGTIMEOUT'(1);
        end
    end

    assign w_sum = {1'b0, w_flight_nxt} + (LGFLIGHT+1)'(w_stb_nxt)
                 + (LGFLIGHT+1)'(w_skid_nxt);
    assign w_stall_nxt = (w_state_nxt == WBB_ABORT) || w_skid_nxt || (w_sum >= FL_THR);

    wb_skid #(.W(RW)) u_skid (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_flush     (w_flush),
        .i_valid     (w_accept),
        .i_data      ({i_we, i_adr, i_dat}),
        .i_ready     (!i_stall),
        .o_valid     (w_stb),
        .o_data      (w_req),
        .o_valid_nxt (w_stb_nxt),
        .o_skid_nxt  (w_skid_nxt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= WBB_IDLE;
            r_cyc    <= 1'b0;
            r_stall  <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_data   <= '0;
            r_flight <= '0;
            r_tmo    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cyc    <= (w_state_nxt == WBB_BUSY);
            r_stall  <= w_stall_nxt;
            // An error on the same cycle swallows the ack.
            r_ack    <= i_ack && r_cyc && !i_err;
            r_err    <= w_abort;
            r_data   <= i_data;
            r_flight <= w_flight_nxt;
            r_tmo    <= w_tmo_nxt;
        end
    end

    assign o_cyc   = r_cyc;
    assign o_stall = r_stall;
    assign o_ack   = r_ack;
    assign o_err   = r_err;
    assign o_data  = r_data;
    assign o_stb   = w_stb;
    assign {o_we, o_adr, o_dat} = w_req;

endmodule

// File: tb/tb_wb_bus_buffer.sv
// Directed bench for wb_bus_buffer with scoreboard queues for issued
// requests and returned read data.
module tb_wb_bus_buffer;

    localparam int DW = 32;
    localparam int AW = 19;
    localparam int RW = 1 + AW + DW;

    logic          i_clk = 1'b0;
    logic          i_rst_n, i_cyc, i_stb, i_we, i_stall, i_ack, i_err;
    logic [AW-1:0] i_adr;
    logic [DW-1:0] i_dat, i_data;
    logic          o_stall, o_ack, o_err, o_cyc, o_stb, o_we;
    logic [DW-1:0] o_data, o_dat;
    logic [AW-1:0] o_adr;

    int n_checks = 0, n_errors = 0, n_iss = 0, n_ackd = 0;
    int n_acc, drv, base_iss, base_ack, max_out, k;
    logic          stall_seen;
    logic [RW-1:0] exp_req[$];
    logic [DW-1:0] exp_dat[$];

    wb_bus_buffer #(.DW(DW), .AW(AW), .LGFLIGHT(2), .LGTIMEOUT(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we),
        .i_adr(i_adr), .i_dat(i_dat), .o_stall(o_stall), .o_ack(o_ack), .o_err(o_err),
        .o_data(o_data), .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we), .o_adr(o_adr),
        .o_dat(o_dat), .i_stall(i_stall), .i_ack(i_ack), .i_err(i_err), .i_data(i_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Score the handshake due at the coming edge, then advance and score returns.
    task automatic tick();
        if (o_stb && !i_stall) begin
            n_iss++;
            chk("issue_expected", 64'(exp_req.size() > 0), 64'(1));
            if (exp_req.size() > 0)
                chk("issue_req", 64'({o_we, o_adr, o_dat}), 64'(exp_req.pop_front()));
        end
        @(posedge i_clk);
        #1;
        if (o_ack) begin
            n_ackd++;
            chk("ack_expected", 64'(exp_dat.size() > 0), 64'(1));
            if (exp_dat.size() > 0)
                chk("ack_data", 64'(o_data), 64'(exp_dat.pop_front()));
        end
    endtask

    task automatic run_single(input string tag);
        i_cyc = 1'b1; i_stb = 1'b1; i_we = 1'b0; i_adr = 19'h12; i_dat = '0;
        chk({tag, "_stall_idle"}, 64'(o_stall), 64'(0));
        exp_req.push_back({1'b0, 19'h12, 32'h0});
        tick();
        i_stb = 1'b0;
        chk({tag, "_stb"}, 64'(o_stb), 64'(1));
        chk({tag, "_cyc"}, 64'(o_cyc), 64'(1));
        tick();
        chk({tag, "_stb_clr"}, 64'(o_stb), 64'(0));
        tick();
        i_ack = 1'b1; i_data = 32'hDEADBEEF;
        exp_dat.push_back(32'hDEADBEEF);
        tick();
        i_ack = 1'b0;
        chk({tag, "_ack"}, 64'(o_ack), 64'(1));
        chk({tag, "_data"}, 64'(o_data), 64'(32'hDEADBEEF));
        tick();
        chk({tag, "_ack_pulse"}, 64'(o_ack), 64'(0));
        i_cyc = 1'b0;
        tick();
        chk({tag, "_cyc_drop"}, 64'(o_cyc), 64'(0));
        chk({tag, "_ackq"}, 64'(exp_dat.size()), 64'(0));
    endtask

    initial begin
        i_rst_n = 1'b0; i_cyc = 1'b0; i_stb = 1'b0; i_we = 1'b0; i_adr = '0; i_dat = '0;
        i_stall = 1'b0; i_ack = 1'b0; i_err = 1'b0; i_data = '0;
        #1;
        chk("rst_cyc", 64'(o_cyc), 64'(0));
        chk("rst_stb", 64'(o_stb), 64'(0));
        chk("rst_stall", 64'(o_stall), 64'(0));
        chk("rst_ack_err", 64'({o_ack, o_err}), 64'(0));
        chk("rst_req", 64'({o_we, o_adr, o_dat}), 64'(0));
        chk("rst_data", 64'(o_data), 64'(0));
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        tick();

        // Single read
        run_single("t1");

        // Four writes against a stalled slave
        n_acc = 0; drv = 0; base_iss = n_iss; base_ack = n_ackd; stall_seen = 1'b0;
        i_cyc = 1'b1; i_we = 1'b1;
        for (int c = 0; c < 40 && drv < 4; c++) begin
            i_stall = (c < 3);
            i_stb = (n_acc < 4);
            i_adr = AW'(n_acc); i_dat = 32'hC0DE0000 + n_acc;
            if (i_stb && !o_stall) begin
                exp_req.push_back({1'b1, i_adr, i_dat});
                n_acc++;
            end
            i_ack = (n_iss - base_iss) > drv;
            if (i_ack) begin
                i_data = 32'h0F00 + drv;
                exp_dat.push_back(i_data);
                drv++;
            end
            tick();
            if (o_stall) stall_seen = 1'b1;
        end
        i_ack = 1'b0; i_stb = 1'b0; i_stall = 1'b0;
        tick();
        chk("t2_stall_seen", 64'(stall_seen), 64'(1));
        chk("t2_issued", 64'(n_iss - base_iss), 64'(4));
        chk("t2_acks", 64'(n_ackd - base_ack), 64'(4));
        chk("t2_reqq", 64'(exp_req.size()), 64'(0));
        i_cyc = 1'b0;
        tick();

        // In-flight limit with reads and no acks
        n_acc = 0; drv = 0; base_iss = n_iss; base_ack = n_ackd; max_out = 0;
        i_cyc = 1'b1; i_we = 1'b0; i_dat = '0;
        for (int c = 0; c < 8; c++) begin
            i_stb = (n_acc < 5); i_adr = AW'(32'h30 + n_acc);
            if (i_stb && !o_stall) begin
                exp_req.push_back({1'b0, i_adr, i_dat});
                n_acc++;
            end
            tick();
            if (n_iss - base_iss > max_out) max_out = n_iss - base_iss;
        end
        chk("t3_issued_le3", 64'((n_iss - base_iss) <= 3), 64'(1));
        chk("t3_stall_held", 64'(o_stall), 64'(1));
        chk("t3_blocked", 64'(n_acc < 5), 64'(1));
        for (int c = 0; c < 60 && drv < 5; c++) begin
            i_stb = (n_acc < 5); i_adr = AW'(32'h30 + n_acc);
            if (i_stb && !o_stall) begin
                exp_req.push_back({1'b0, i_adr, i_dat});
                n_acc++;
            end
            i_ack = (n_iss - base_iss) > drv;
            if (i_ack) begin
                i_data = 32'hA0000000 + drv;
                exp_dat.push_back(i_data);
                drv++;
            end
            tick();
            if (n_iss - base_iss - drv > max_out) max_out = n_iss - base_iss - drv;
        end
        i_ack = 1'b0; i_stb = 1'b0;
        tick();
        chk("t3_accepted", 64'(n_acc), 64'(5));
        chk("t3_issued", 64'(n_iss - base_iss), 64'(5));
        chk("t3_acks", 64'(n_ackd - base_ack), 64'(5));
        chk("t3_max_inflight", 64'(max_out <= 3), 64'(1));
        i_cyc = 1'b0;
        tick();

        // Timeout abort
        i_cyc = 1'b1; i_stb = 1'b1; i_we = 1'b0; i_adr = 19'h44; i_dat = '0;
        exp_req.push_back({1'b0, 19'h44, 32'h0});
        tick();
        i_stb = 1'b0;
        tick();
        k = 0;
        for (int c = 0; c < 40 && !o_err; c++) begin
            tick();
            k++;
        end
        chk("t4_err_latency", 64'(k), 64'(16));
        chk("t4_cyc", 64'(o_cyc), 64'(0));
        chk("t4_stb", 64'(o_stb), 64'(0));
        chk("t4_stall", 64'(o_stall), 64'(1));
        i_stb = 1'b1; i_adr = 19'h45;
        tick();
        chk("t4_err_pulse", 64'(o_err), 64'(0));
        chk("t4_abort_stall", 64'(o_stall), 64'(1));
        chk("t4_abort_stb", 64'(o_stb), 64'(0));
        i_stb = 1'b0; i_cyc = 1'b0;
        tick();
        chk("t4_release_stall", 64'(o_stall), 64'(0));

        // Bus error on the second of three reads, with a simultaneous ack
        n_acc = 0; drv = 0; base_iss = n_iss; base_ack = n_ackd;
        i_cyc = 1'b1; i_we = 1'b0;
        for (int c = 0; c < 30 && (n_iss - base_iss) < 3; c++) begin
            i_stb = (n_acc < 3); i_adr = AW'(32'h50 + n_acc);
            if (i_stb && !o_stall) begin
                exp_req.push_back({1'b0, i_adr, i_dat});
                n_acc++;
            end
            i_ack = (drv == 0) && (n_iss - base_iss) >= 1;
            if (i_ack) begin
                i_data = 32'h11111111;
                exp_dat.push_back(i_data);
                drv++;
            end
            tick();
        end
        i_stb = 1'b0;
        i_err = 1'b1; i_ack = 1'b1; i_data = 32'h22222222;
        tick();
        chk("t5_err", 64'(o_err), 64'(1));
        chk("t5_ack_beaten", 64'(o_ack), 64'(0));
        chk("t5_cyc", 64'(o_cyc), 64'(0));
        i_err = 1'b0; i_data = 32'h33333333;
        tick();
        chk("t5_late_ack", 64'(o_ack), 64'(0));
        chk("t5_err_pulse", 64'(o_err), 64'(0));
        i_ack = 1'b0;
        chk("t5_acks", 64'(n_ackd - base_ack), 64'(1));
        i_cyc = 1'b0;
        tick();

        // Dropping cyc wins over an error and flushes pending requests
        i_cyc = 1'b1; i_stall = 1'b1; i_stb = 1'b1; i_adr = 19'h60;
        tick();
        i_adr = 19'h61;
        tick();
        i_stb = 1'b0;
        chk("t5b_skid_stall", 64'(o_stall), 64'(1));
        i_cyc = 1'b0; i_err = 1'b1;
        tick();
        chk("t5b_no_err", 64'(o_err), 64'(0));
        chk("t5b_flush", 64'({o_cyc, o_stb, o_stall}), 64'(0));
        i_err = 1'b0; i_stall = 1'b0;
        tick();

        // Asynchronous reset mid-burst
        i_cyc = 1'b1; i_stall = 1'b1; i_stb = 1'b1; i_we = 1'b1; i_adr = 19'h70; i_dat = 32'h5A5A;
        tick();
        i_adr = 19'h71;
        tick();
        i_stb = 1'b0;
        chk("t6_pre_stall", 64'(o_stall), 64'(1));
        #2 i_rst_n = 1'b0;
        #1;
        chk("t6_rst_ctl", 64'({o_cyc, o_stb, o_stall, o_ack, o_err}), 64'(0));
        chk("t6_rst_req", 64'({o_we, o_adr, o_dat}), 64'(0));
        exp_req.delete();
        exp_dat.delete();
        i_cyc = 1'b0; i_stall = 1'b0; i_we = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        tick();
        run_single("t6");

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
